// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types, widths and address helper for the peripheral bus.
// Exports: state_t (bus FSM states), DATA_W / STRB_W (cpu data and byte-enable widths),
//          win_idx() (window number of a byte address).
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Window number of a byte address. Plain 32-bit unsigned arithmetic, so an
    // address below base wraps to a huge index; callers must still check addr >= base.
    function automatic logic [31:0] win_idx(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned addr_w);
        return (addr - base) >> addr_w;
    endfunction

endpackage

// File: rtl/periph_bus_decode.sv
// periph_bus_decode: combinational byte-address to peripheral-window decoder.
// Ports: addr_i (byte address) -> hit_o (address falls in one of the N_SLAVES windows),
//        sel_o (one-hot window select, all zero on a miss).
module periph_bus_decode
    import periph_bus_pkg::*;
#(
    parameter int          N_SLAVES  = 4,
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic [31:0]         addr_i,
    output logic                hit_o,
    output logic [N_SLAVES-1:0] sel_o
);

    logic [31:0] idx;

    always_comb begin
        idx   = win_idx(addr_i, BASE_ADDR, ADDR_W);
        hit_o = (addr_i >= BASE_ADDR) && (idx < 32'(N_SLAVES));
        sel_o = '0;
        if (hit_o) begin
            sel_o = N_SLAVES'(1) << idx;
        end
    end

endmodule

// File: rtl/periph_bus.sv
// periph_bus: address-decoded, handshaked cpu-to-peripheral bus, one transaction in flight.
// Ports: cpu side req/we/addr/wdata/wstrb in, ack/err/rdata out; peripheral side one-hot
//        p_sel plus registered we/addr/wdata/wstrb out, per-slave p_ack and p_rdata slices in.
// Optional: define PERIPH_BUS_TIMEOUT_EN to error out ACCESS after TIMEOUT cycles without ack.
// System wiring: uart sits on window 0, led on window 1; each peripheral uses
// p_sel_o[k] & p_we_o as its write strobe.
module periph_bus
    import periph_bus_pkg::*;
#(
    parameter int          N_SLAVES  = 4,
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [31:0]                  addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [STRB_W-1:0]            wstrb_i,
    output logic                         ack_o,
    output logic                         err_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [N_SLAVES-1:0]          p_sel_o,
    output logic                         p_we_o,
    output logic [ADDR_W-1:0]            p_addr_o,
    output logic [DATA_W-1:0]            p_wdata_o,
    output logic [STRB_W-1:0]            p_wstrb_o,
    input  logic [N_SLAVES-1:0]          p_ack_i,
    input  logic [N_SLAVES*DATA_W-1:0]   p_rdata_i
);

    state_t                state_q, state_d;
    logic [N_SLAVES-1:0]   sel_q,   sel_d;
    logic                  we_q,    we_d;
    logic [ADDR_W-1:0]     addr_q,  addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q,   err_d;

    logic                  dec_hit;
    logic [N_SLAVES-1:0]   dec_sel;
    logic [DATA_W-1:0]     rd_mux;
    logic                  slv_ack;
    logic                  expired;

    periph_bus_decode #(
        .N_SLAVES  (N_SLAVES),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .addr_i (addr_i),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel)
    );

    // sel_q is one-hot, so OR-ing the selected slices is a plain mux.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_q[k]) begin
                rd_mux = rd_mux | p_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Only the selected peripheral may complete the access.
    assign slv_ack = |(p_ack_i & sel_q);

`ifdef PERIPH_BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Counter holds 0 in the first ACCESS cycle, so TIMEOUT-1 marks the last one.
    assign expired = (cnt_q == 8'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef PERIPH_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i[ADDR_W-1:0];
                    wdata_d = wdata_i;
                    wstrb_d = wstrb_i;
`ifdef PERIPH_BUS_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    if (dec_hit) begin
                        sel_d   = dec_sel;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
`ifdef PERIPH_BUS_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                // A completing ack takes priority over an expiring timeout.
                if (slv_ack) begin
                    rdata_d = we_q ? '0 : rd_mux;
                    sel_d   = '0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (expired) begin
                    rdata_d = '0;
                    sel_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef PERIPH_BUS_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef PERIPH_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // RESP lasts exactly one cycle, which makes ack_o a single-cycle pulse.
    assign ack_o     = (state_q == RESP);
    assign err_o     = ack_o & err_q;
    assign rdata_o   = rdata_q;
    assign p_sel_o   = sel_q;
    assign p_we_o    = we_q;
    assign p_addr_o  = addr_q;
    assign p_wdata_o = wdata_q;
    assign p_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_periph_bus.sv
`timescale 1ns/1ps
module tb_periph_bus;

    localparam int N = 4;

    logic           clk_i;
    logic           rstn_i;
    logic           req_i;
    logic           we_i;
    logic [31:0]    addr_i;
    logic [31:0]    wdata_i;
    logic [3:0]     wstrb_i;
    logic           ack_o;
    logic           err_o;
    logic [31:0]    rdata_o;
    logic [N-1:0]   p_sel_o;
    logic           p_we_o;
    logic [11:0]    p_addr_o;
    logic [31:0]    p_wdata_o;
    logic [3:0]     p_wstrb_o;
    logic [N-1:0]   p_ack_i;
    logic [N*32-1:0] p_rdata_i;

    int checks = 0;
    int errors = 0;

    periph_bus #(
        .N_SLAVES  (N),
        .ADDR_W    (12),
        .BASE_ADDR (32'h1000_0000),
        .TIMEOUT   (8)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .wstrb_i   (wstrb_i),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .rdata_o   (rdata_o),
        .p_sel_o   (p_sel_o),
        .p_we_o    (p_we_o),
        .p_addr_o  (p_addr_o),
        .p_wdata_o (p_wdata_o),
        .p_wstrb_o (p_wstrb_o),
        .p_ack_i   (p_ack_i),
        .p_rdata_i (p_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  ack_mask;   // slave ack driven in ACCESS cycle index dly
        int          dly;
        logic [3:0]  spur;       // acks driven in the ACCESS cycles before dly
        logic [3:0]  exp_sel;
        logic [11:0] exp_paddr;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;    // edges from req sample edge to the edge that samples ack_o
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        we_i    = v.we;
        addr_i  = v.addr;
        wdata_i = v.wdata;
        wstrb_i = v.wstrb;
        req_i   = 1'b1;
        @(posedge clk_i); #1;
        lat = 1;
        chk({v.name, " sel"}, 32'(p_sel_o), 32'(v.exp_sel));
        if (v.exp_sel != 4'b0000) begin
            chk({v.name, " paddr"}, 32'(p_addr_o), 32'(v.exp_paddr));
            chk({v.name, " pwe"},   32'(p_we_o),   32'(v.we));
            chk({v.name, " pwdata"}, p_wdata_o,    v.wdata);
            chk({v.name, " pwstrb"}, 32'(p_wstrb_o), 32'(v.wstrb));
        end
        while (ack_o !== 1'b1 && lat < 40) begin
            if (lat - 1 == v.dly)     p_ack_i = v.ack_mask;
            else if (lat - 1 < v.dly) p_ack_i = v.spur;
            else                      p_ack_i = '0;
            @(posedge clk_i); #1;
            lat++;
        end
        p_ack_i = '0;
        req_i   = 1'b0;
        chk({v.name, " ack latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " err"},   32'(err_o), 32'(v.exp_err));
        chk({v.name, " rdata"}, rdata_o,    v.exp_rdata);
        chk({v.name, " sel at ack"}, 32'(p_sel_o), 32'h0);
        @(posedge clk_i); #1;
        chk({v.name, " ack one cycle"}, 32'(ack_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        logic saw_ack;
        logic sel_ok;

        vecs[0] = '{"wr_s0",        1'b1, 32'h1000_0000, 32'h0000_0041, 4'hF, 4'b0001, 0, 4'b0000, 4'b0001, 12'h000, 1'b0, 32'h0000_0000, 2};
        vecs[1] = '{"rd_s1_slow",   1'b0, 32'h1000_1004, 32'h0,         4'hF, 4'b0010, 5, 4'b0000, 4'b0010, 12'h004, 1'b0, 32'hDEAD_BEEF, 7};
        vecs[2] = '{"rd_past_end",  1'b0, 32'h1000_4000, 32'h0,         4'hF, 4'b0000, 0, 4'b0000, 4'b0000, 12'h000, 1'b1, 32'h0000_0000, 1};
        vecs[3] = '{"rd_below_base",1'b0, 32'h0FFF_FFFC, 32'h0,         4'hF, 4'b0000, 0, 4'b0000, 4'b0000, 12'h000, 1'b1, 32'h0000_0000, 1};
        vecs[4] = '{"rd_s2_spur",   1'b0, 32'h1000_2010, 32'h0,         4'hF, 4'b0100, 3, 4'b1001, 4'b0100, 12'h010, 1'b0, 32'h2222_2222, 5};
        vecs[5] = '{"rd_s3_last",   1'b0, 32'h1000_3FFF, 32'h0,         4'hF, 4'b1000, 0, 4'b0000, 4'b1000, 12'hFFF, 1'b0, 32'h3333_3333, 2};
        vecs[6] = '{"wr_s3_strb",   1'b1, 32'h1000_3008, 32'hCAFE_F00D, 4'h5, 4'b1000, 1, 4'b0000, 4'b1000, 12'h008, 1'b0, 32'h0000_0000, 3};
        vecs[7] = '{"rd_top",       1'b0, 32'hFFFF_FFFF, 32'h0,         4'hF, 4'b0000, 0, 4'b0000, 4'b0000, 12'h000, 1'b1, 32'h0000_0000, 1};

        rstn_i    = 1'b0;
        req_i     = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        wdata_i   = '0;
        wstrb_i   = '0;
        p_ack_i   = '0;
        p_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset ack",    32'(ack_o),     32'h0);
        chk("reset err",    32'(err_o),     32'h0);
        chk("reset rdata",  rdata_o,        32'h0);
        chk("reset sel",    32'(p_sel_o),   32'h0);
        chk("reset pwe",    32'(p_we_o),    32'h0);
        chk("reset paddr",  32'(p_addr_o),  32'h0);
        chk("reset pwdata", p_wdata_o,      32'h0);
        chk("reset pwstrb", 32'(p_wstrb_o), 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of an ACCESS, then let the held request retry.
        we_i   = 1'b0;
        addr_i = 32'h1000_1000;
        req_i  = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_mid sel before", 32'(p_sel_o), 32'h2);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("rst_mid sel async drop", 32'(p_sel_o), 32'h0);
        saw_ack = ack_o;
        repeat (2) begin
            @(posedge clk_i); #1;
            if (ack_o === 1'b1) saw_ack = 1'b1;
        end
        chk("rst_mid no ack", 32'(saw_ack), 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        cnt = 0;
        while (ack_o !== 1'b1 && cnt < 20) begin
            p_ack_i = p_sel_o & 4'b0010;
            @(posedge clk_i); #1;
            cnt++;
        end
        p_ack_i = '0;
        req_i   = 1'b0;
        chk("rst_retry ack edges", 32'(cnt), 32'd2);
        chk("rst_retry err",   32'(err_o), 32'h0);
        chk("rst_retry rdata", rdata_o,    32'hDEAD_BEEF);
        @(posedge clk_i); #1;

`ifdef PERIPH_BUS_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{"to_silent",   1'b1, 32'h1000_2000, 32'h0000_0005, 4'hF, 4'b0000, 99, 4'b0000, 4'b0100, 12'h000, 1'b1, 32'h0000_0000, 9};
            run_vec(tv);
            tv = '{"to_ack_last", 1'b0, 32'h1000_2004, 32'h0,         4'hF, 4'b0100, 7,  4'b0000, 4'b0100, 12'h004, 1'b0, 32'h2222_2222, 9};
            run_vec(tv);
        end
`else
        // Without the timeout a silent slave stalls the bus until it answers.
        we_i    = 1'b1;
        addr_i  = 32'h1000_3000;
        wdata_i = 32'h0000_00AA;
        wstrb_i = 4'hF;
        req_i   = 1'b1;
        @(posedge clk_i); #1;
        saw_ack = 1'b0;
        sel_ok  = 1'b1;
        repeat (30) begin
            @(posedge clk_i); #1;
            if (ack_o === 1'b1)      saw_ack = 1'b0 | 1'b1;
            if (p_sel_o !== 4'b1000) sel_ok  = 1'b0;
        end
        chk("silent no ack",   32'(saw_ack), 32'h0);
        chk("silent sel held", 32'(sel_ok),  32'h1);
        p_ack_i = 4'b1000;
        @(posedge clk_i); #1;
        p_ack_i = '0;
        req_i   = 1'b0;
        chk("silent late ack", 32'(ack_o), 32'h1);
        chk("silent err",      32'(err_o), 32'h0);
        chk("silent rdata",    rdata_o,    32'h0);
        @(posedge clk_i); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
